spi_dac_responder: RTL and testbench

- SPI mode-0 target: the responder end of the DAC serial link.
- Stands in for the DAC on the FPGA side. It receives 8-bit frames from an SPI initiator on sclk/cs/mosi and returns a word on miso.
- Oversamples all SPI pins on the system clock. Delivers each received word with a one-cycle valid strobe and flags malformed frames.
- Used as an on-chip DAC model for loopback bring-up and as the responder in link verification.

---
 rtl/spi_dac_responder.sv | 148 ++++++++++++++
 tb/tb_spi_dac_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_dac_responder.sv
// rtl/spi_dac_responder.sv - SPI mode-0 responder standing in for the DAC; SPI_ECHO_EN makes it echo the last good word
module spi_dac_responder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_END
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic [SYNC_STAGES:0]   fill;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       rx_shift;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       load_word;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sync_ready;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // After reset the chain holds reset values, not pin samples; a cs fall only
    // counts once the previous-sample register carries a genuine high cs.
    assign sync_ready = fill[SYNC_STAGES];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = sync_ready & cs_prev & ~cs_s;

`ifdef SPI_ECHO_EN
    assign load_word = rx_data;
`else
    assign load_word = tx_data;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            fill      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            miso      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    miso <= 1'b0;
                    if (cs_fall) begin
                        tx_shift <= load_word;
                        miso     <= load_word[WIDTH-1];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    busy <= 1'b1;
                    // cs rise has priority over any sclk edge seen in the same cycle
                    if (cs_rise) begin
                        miso  <= 1'b0;
                        state <= ST_END;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                        if (bit_cnt != CW'(WIDTH + 1)) begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt < CW'(WIDTH)) begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            miso     <= tx_shift[WIDTH-2];
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                end
                ST_END: begin
                    if (bit_cnt == CW'(WIDTH)) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_responder.sv
// tb/tb_spi_dac_responder.sv - scoreboard bench for spi_dac_responder (expectations follow SPI_ECHO_EN when defined)
module tb_spi_dac_responder;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       n_reset;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int   passed;
    int   total;
    int   cyc;
    int   cs_rise_cyc;
    logic [7:0] last_good;

    exp_t exp_q[$];
    logic miso_q[$];

    spi_dac_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: every rx_valid / frame_err pops one scoreboard entry.
    always @(negedge clk) begin
        if (n_reset && (rx_valid || frame_err)) begin
            chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {31'd0, frame_err}, {31'd0, rx_valid});
                chk("unexpected_strobe_any", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e = exp_q.pop_front();
                lat = cyc - cs_rise_cyc;
                chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("strobe_latency_3to5", {31'd0, (lat >= 3 && lat <= 5)}, 32'd1);
            end
        end
    end

    // miso monitor: initiator samples miso on each sclk rise while selected.
    always @(posedge sclk) begin
        if (n_reset && !cs && miso_q.size() > 0) begin
            logic b;
            b = miso_q.pop_front();
            chk("miso_bit", {31'd0, miso}, {31'd0, b});
        end
    end

    task automatic spi_frame(input logic [15:0] bits, input int nbits,
                             input logic [7:0] txw, input logic [7:0] tx_next, input int gap);
        logic [7:0] word;
        exp_t       e;
        tx_data = txw;
`ifdef SPI_ECHO_EN
        word = last_good;
`else
        word = txw;
`endif
        for (int i = 0; i < nbits; i++) begin
            miso_q.push_back((i < 8) ? word[7-i] : 1'b0);
        end
        if (nbits == 8) begin
            e.err     = 1'b0;
            e.data    = bits[7:0];
            last_good = bits[7:0];
        end else begin
            e.err  = 1'b1;
            e.data = last_good;
        end
        exp_q.push_back(e);
        cs   = 1'b0;
        mosi = bits[nbits-1];
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            mosi = (i + 1 < nbits) ? bits[nbits-2-i] : 1'b0;
            if (i == 3) begin
                tx_data = tx_next;
                chk("busy_mid_frame", {31'd0, busy}, 32'd1);
            end
            repeat (4) @(negedge clk);
        end
        cs          = 1'b1;
        cs_rise_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed      = 0;
        total       = 0;
        cyc         = 0;
        cs_rise_cyc = 0;
        last_good   = 8'h00;
        n_reset     = 1'b0;
        cs          = 1'b0;
        sclk        = 1'b0;
        mosi        = 1'b1;
        tx_data     = 8'hFF;

        repeat (3) @(negedge clk) sclk = ~sclk;
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_miso", {31'd0, miso}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);

        n_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (4) @(negedge clk);
            sclk = ~sclk;
        end
        chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (8) @(negedge clk);

        spi_frame(16'h003C, 8, 8'hA5, 8'hA5, 8);
        spi_frame(16'h0016, 5, 8'h0F, 8'h0F, 8);
        chk("rx_data_after_short", {24'd0, rx_data}, 32'h3C);
        spi_frame(16'h01FF, 9, 8'h81, 8'h81, 8);
        chk("rx_data_after_long", {24'd0, rx_data}, 32'h3C);
        spi_frame(16'h0001, 8, 8'hC3, 8'h3C, 2);
        spi_frame(16'h0080, 8, 8'h3C, 8'h3C, 8);
        spi_frame(16'h005A, 8, 8'h11, 8'h11, 8);
        spi_frame(16'h0000, 8, 8'h22, 8'h22, 20);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("miso_queue_drained", miso_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
